ex_operand_stage: RTL and testbench
===================================

# ex_operand_stage

ID/EX pipeline register and operand-selection stage of the 32-bit MIPS pipeline, directly upstream of the ALU. It registers decoded instruction fields on each clock. It decodes `alu_op`/`funct` into the 4-bit ALU control code and drives `op_1`, `op_2` and `alu_ctrl` to the ALU. It also resolves RAW hazards, by forwarding from EX/MEM and MEM/WB and by stalling decode on load-use.

## Interface
- `RST_PC_UNUSED`: no parameters; all widths are fixed by the 32-bit ISA.
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous and active-high.
- `id_valid` in 1: the decode stage holds a real instruction.
- `id_rs_data`, `id_rt_data` in 32: register-file read data.
- `id_imm` in 32: sign-extended immediate.
- `id_rs`, `id_rt`, `id_rd` in 5: register indices.
- `id_alu_op` in 2: main-decoder ALU class.
- `id_funct` in 6: R-type funct field.
- `id_alu_src`, `id_reg_dst`, `id_reg_write`, `id_mem_read`, `id_mem_write` in 1: decoder controls.
- `flush` in 1: branch/exception squash of the instruction entering EX.
- `exmem_reg_write` in 1, `exmem_rd` in 5, `exmem_result` in 32: EX/MEM forward source.
- `memwb_reg_write` in 1, `memwb_rd` in 5, `memwb_result` in 32: MEM/WB forward source.
- `op_1`, `op_2` out 32: ALU operands.
- `alu_ctrl` out 4: ALU operation code.
- `ex_store_data` out 32: forwarded rt value, for stores.
- `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write` out 1: registered controls.
- `ex_dest` out 5: destination register.
- `illegal_funct` out 1: unknown funct under R-type.
- `stall_req` out 1: decode/PC must hold this cycle.

## Operation
- ALU control decode (combinational on `id_*`, then registered):
  - `alu_op` 00 → 0010 (ADD).
  - `alu_op` 01 → 0110 (SUB).
  - `alu_op` 11 → 0001 (OR).
  - `alu_op` 10 → decode funct:
    - 100000 → 0010
    - 100010 → 0110
    - 100100 → 0000
    - 100101 → 0001
    - 101010 → 0111
    - 100111 → 1100
    - any other funct → 0000, with `illegal_funct`=1 (registered together with the instruction).
- `ex_dest` = `id_reg_dst` ? `id_rd` : `id_rt`, captured at the register.
- Register update priority, evaluated each cycle:
  - `rst` → clear all fields.
  - Otherwise `flush` → load a bubble.
  - Otherwise load-use hazard → load a bubble.
  - Otherwise load the `id_*` fields, with `ex_valid` = `id_valid`.
- Bubble definition: `valid`, `reg_write`, `mem_read`, `mem_write` and `illegal` all 0; data fields are don't-care and are cleared to 0.
- Load-use hazard: `ex_valid & ex_mem_read & id_valid & (ex_dest != 0) & (ex_dest == id_rs | (ex_dest == id_rt & !id_alu_src))`. When true, `stall_req`=1 combinationally in the same cycle. Sources of the stores' rt count as well: `id_mem_write` forces the rt compare even when `id_alu_src`=1.
- `stall_req` is suppressed (0) when `flush`=1.
- Forwarding (combinational, applied after the register to the registered rs/rt data):
  - Priority: EX/MEM first, then MEM/WB, then the registered value.
  - A source matches only when its `reg_write`=1, its `rd`≠0, and its `rd` equals the registered index.
  - Register $0 is never forwarded.
- `op_1` = forwarded rs.
- `ex_store_data` = forwarded rt.
- `op_2` = registered `alu_src` ? registered imm : forwarded rt.
- When `ex_valid`=0, `op_1`, `op_2` and `ex_store_data` are forced to 0 and `alu_ctrl` is 0000.

## Timing
- Reset values: all outputs 0 (`op_1`, `op_2`, `alu_ctrl`, `ex_store_data`, `ex_dest`, every control output, `illegal_funct`, `stall_req`).
- Latency: `id_*` fields become visible on the outputs one clock after capture.
- Forward buses affect `op_1`/`op_2` in the same cycle (zero latency).
- `stall_req` is a same-cycle combinational output. The bubble appears on the next edge, and the held decode instruction is recaptured one cycle later.
- Simultaneous `flush` and hazard: the flush wins and `stall_req`=0.
- `rst` asserted mid-stall: the register clears on that edge and `stall_req` drops with it, because `ex_valid`=0.

## Configuration
- `EX_FWD_EN` defined: forwarding muxes as described; stall occurs on load-use only.
- `EX_FWD_EN` undefined:
  - No forwarding muxes; operands come straight from the register.
  - `stall_req` is asserted for any RAW hazard where `id_rs`/`id_rt` (nonzero) matches either `ex_dest` with `ex_reg_write` set, or `exmem_rd` with `exmem_reg_write` set.
  - MEM/WB hazards are covered by the write-first register file.

## Structure
- Shared package `mips_pkg` holds:
  - the ALU control localparams (`ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SUB`, `ALU_SLT`, `ALU_NOR`);
  - the `alu_op` and funct encodings;
  - the packed struct `idex_t` for the registered fields.
- One sub-module, `alu_ctrl_dec` (combinational funct/`alu_op` decode), shared with any future EX variants.

## Test plan
- Reset: hold `rst` for 2 cycles with garbage on `id_*` → all outputs 0; after release, `add` (alu_op=10, funct=100000, rs=5, rt=6) → next cycle `alu_ctrl`=0010, `op_1`/`op_2` equal to the rs/rt data.
- EX/MEM forward: registered rs=8; `exmem_reg_write`=1, `exmem_rd`=8, `exmem_result`=0x1234 and MEM/WB also targets 8 with 0x5678 → `op_1`=0x1234. Repeat with rd=0 → no forward.
- Load-use: `lw` $9 sits in EX; decode holds `sub` using $9 → `stall_req`=1; next edge EX holds a bubble (`ex_valid`=0, `op_1`=0); the following edge captures `sub` with `alu_ctrl`=0110.
- Flush with hazard in the same cycle → `stall_req`=0, bubble loaded, no duplicate instruction.
- Illegal funct 111111 under alu_op=10 → `alu_ctrl`=0000, `illegal_funct`=1 for exactly that instruction.
- With `EX_FWD_EN` undefined: back-to-back `addi` $3 then `or` using $3 → `stall_req` held for 2 cycles, correct operands once released.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU control codes, decoder encodings,
// the ID/EX register layout and small hazard-compare helpers.
package mips_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        illegal;
        logic        alu_src;
        logic [3:0]  alu_ctrl;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
    } idex_t;

    // True when a nonzero destination feeds one of the decode sources.
    function automatic logic src_match(input logic [4:0] dst, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic rt_used);
        return (dst != 5'd0) && ((dst == rs) || ((dst == rt) && rt_used));
    endfunction

    function automatic logic fwd_hit(input logic we, input logic [4:0] rd,
                                     input logic [4:0] idx);
        return we && (rd != 5'd0) && (rd == idx);
    endfunction

endpackage

// File: rtl/ex_operand_stage_if.sv
// Decode/EX boundary bundle: decoded fields in, forward sources in,
// ALU operands, registered controls and stall request out.
interface ex_operand_stage_if;

    logic        id_valid;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [31:0] id_imm;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [1:0]  id_alu_op;
    logic [5:0]  id_funct;
    logic        id_alu_src;
    logic        id_reg_dst;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        id_mem_write;
    logic        flush;

    logic        exmem_reg_write;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_result;

    logic [31:0] op_1;
    logic [31:0] op_2;
    logic [3:0]  alu_ctrl;
    logic [31:0] ex_store_data;
    logic        ex_valid;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [4:0]  ex_dest;
    logic        illegal_funct;
    logic        stall_req;

    modport master (
        output id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
               id_alu_op, id_funct, id_alu_src, id_reg_dst, id_reg_write,
               id_mem_read, id_mem_write, flush,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        input  op_1, op_2, alu_ctrl, ex_store_data, ex_valid, ex_reg_write,
               ex_mem_read, ex_mem_write, ex_dest, illegal_funct, stall_req
    );

    modport slave (
        input  id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
               id_alu_op, id_funct, id_alu_src, id_reg_dst, id_reg_write,
               id_mem_read, id_mem_write, flush,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        output op_1, op_2, alu_ctrl, ex_store_data, ex_valid, ex_reg_write,
               ex_mem_read, ex_mem_write, ex_dest, illegal_funct, stall_req
    );

endinterface

// File: rtl/ex_operand_stage_alu_ctrl_dec.sv
// Combinational main-decoder class / funct to 4-bit ALU control decode.
// Unknown R-type funct yields AND with the illegal flag raised.
module alu_ctrl_dec
    import mips_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] alu_ctrl,
    output logic       illegal
);

    always_comb begin
        alu_ctrl = ALU_AND;
        illegal  = 1'b0;
        case (alu_op)
            ALUOP_ADD: alu_ctrl = ALU_ADD;
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            ALUOP_OR:  alu_ctrl = ALU_OR;
            default: begin
                case (funct)
                    FN_ADD:  alu_ctrl = ALU_ADD;
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    FN_NOR:  alu_ctrl = ALU_NOR;
                    default: illegal  = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX register with ALU operand selection and RAW hazard handling.
// Define EX_FWD_EN for EX/MEM + MEM/WB forwarding; otherwise decode stalls on RAW.
module ex_operand_stage
    import mips_pkg::*;
(
    input logic          clk,
    input logic          rst,
    ex_operand_stage_if.slave bus
);

    logic [3:0]  id_ctrl;
    logic        id_illegal;
    idex_t       id_fields;
    idex_t       ex_q;
    logic        rt_used;
    logic        load_use;
    logic        stall_raw;
    logic [31:0] fwd_rs;
    logic [31:0] fwd_rt;

    alu_ctrl_dec u_alu_ctrl_dec (
        .alu_op   (bus.id_alu_op),
        .funct    (bus.id_funct),
        .alu_ctrl (id_ctrl),
        .illegal  (id_illegal)
    );

    // Stores read rt as data even though their operand B is the immediate.
    assign rt_used = !bus.id_alu_src || bus.id_mem_write;

    assign load_use = ex_q.valid && ex_q.mem_read && bus.id_valid &&
                      src_match(ex_q.dest, bus.id_rs, bus.id_rt, rt_used);

`ifdef EX_FWD_EN
    assign stall_raw = load_use;
`else
    logic ex_raw;
    logic exmem_raw;

    assign ex_raw    = ex_q.valid && ex_q.reg_write &&
                       src_match(ex_q.dest, bus.id_rs, bus.id_rt, rt_used);
    assign exmem_raw = bus.exmem_reg_write &&
                       src_match(bus.exmem_rd, bus.id_rs, bus.id_rt, rt_used);
    assign stall_raw = load_use || (bus.id_valid && (ex_raw || exmem_raw));
`endif

    assign bus.stall_req = stall_raw && !bus.flush;

    always_comb begin
        id_fields           = '0;
        id_fields.valid     = bus.id_valid;
        id_fields.reg_write = bus.id_reg_write;
        id_fields.mem_read  = bus.id_mem_read;
        id_fields.mem_write = bus.id_mem_write;
        id_fields.illegal   = id_illegal;
        id_fields.alu_src   = bus.id_alu_src;
        id_fields.alu_ctrl  = id_ctrl;
        id_fields.rs        = bus.id_rs;
        id_fields.rt        = bus.id_rt;
        id_fields.dest      = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
        id_fields.rs_data   = bus.id_rs_data;
        id_fields.rt_data   = bus.id_rt_data;
        id_fields.imm       = bus.id_imm;
    end

    // Flush and any stall both insert an all-zero bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else if (bus.flush || stall_raw) begin
            ex_q <= '0;
        end else begin
            ex_q <= id_fields;
        end
    end

`ifdef EX_FWD_EN
    logic unused_fwd;
    assign unused_fwd = 1'b0;

    always_comb begin
        fwd_rs = ex_q.rs_data;
        if (fwd_hit(bus.exmem_reg_write, bus.exmem_rd, ex_q.rs)) begin
            fwd_rs = bus.exmem_result;
        end else if (fwd_hit(bus.memwb_reg_write, bus.memwb_rd, ex_q.rs)) begin
            fwd_rs = bus.memwb_result;
        end
    end

    always_comb begin
        fwd_rt = ex_q.rt_data;
        if (fwd_hit(bus.exmem_reg_write, bus.exmem_rd, ex_q.rt)) begin
            fwd_rt = bus.exmem_result;
        end else if (fwd_hit(bus.memwb_reg_write, bus.memwb_rd, ex_q.rt)) begin
            fwd_rt = bus.memwb_result;
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{bus.exmem_result, bus.memwb_reg_write, bus.memwb_rd,
                          bus.memwb_result, ex_q.rs, ex_q.rt};

    assign fwd_rs = ex_q.rs_data;
    assign fwd_rt = ex_q.rt_data;
`endif

    always_comb begin
        bus.op_1          = '0;
        bus.op_2          = '0;
        bus.ex_store_data = '0;
        bus.alu_ctrl      = ALU_AND;
        if (ex_q.valid) begin
            bus.op_1          = fwd_rs;
            bus.op_2          = ex_q.alu_src ? ex_q.imm : fwd_rt;
            bus.ex_store_data = fwd_rt;
            bus.alu_ctrl      = ex_q.alu_ctrl;
        end
    end

    assign bus.ex_valid      = ex_q.valid;
    assign bus.ex_reg_write  = ex_q.reg_write;
    assign bus.ex_mem_read   = ex_q.mem_read;
    assign bus.ex_mem_write  = ex_q.mem_write;
    assign bus.ex_dest       = ex_q.dest;
    assign bus.illegal_funct = ex_q.illegal;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: an instruction-level model predicts
// each cycle's outputs; a negedge monitor compares. Follows EX_FWD_EN.
module tb_ex_operand_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_operand_stage_if bus ();

    ex_operand_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit        valid, rw, mr, mw, ill, src;
        bit [3:0]  ctrl;
        bit [4:0]  rs, rt, dest;
        bit [31:0] rsd, rtd, imm;
    } slot_t;

    typedef struct {
        bit [31:0] op1, op2, store;
        bit [3:0]  ctrl;
        bit        valid, rw, mr, mw, ill, stall;
        bit [4:0]  dest;
    } exp_t;

    exp_t  sb[$];
    slot_t m_ex;
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    bit    last_stall = 0;
    bit    fwd_ovr = 0;
    // downstream pipeline model feeding the forward buses
    bit        em_rw, mw_rw;
    bit [4:0]  em_rd, mw_rd;
    bit [31:0] em_res, mw_res;

    function automatic bit [4:0] ref_ctrl(input bit [1:0] op, input bit [5:0] f);
        if (op == 2'b00) return 5'b0_0010;
        if (op == 2'b01) return 5'b0_0110;
        if (op == 2'b11) return 5'b0_0001;
        case (f)
            6'b100000: return 5'b0_0010;
            6'b100010: return 5'b0_0110;
            6'b100100: return 5'b0_0000;
            6'b100101: return 5'b0_0001;
            6'b101010: return 5'b0_0111;
            6'b100111: return 5'b0_1100;
            default:   return 5'b1_0000;
        endcase
    endfunction

    function automatic bit decode_reads(input bit [4:0] r);
        if (r == 0) return 0;
        if (bus.id_rs == r) return 1;
        return (bus.id_rt == r) && (!bus.id_alu_src || bus.id_mem_write);
    endfunction

    function automatic bit ref_hazard();
        if (!bus.id_valid) return 0;
`ifdef EX_FWD_EN
        return m_ex.valid && m_ex.mr && decode_reads(m_ex.dest);
`else
        return (m_ex.valid && (m_ex.rw || m_ex.mr) && decode_reads(m_ex.dest)) ||
               (bus.exmem_reg_write && decode_reads(bus.exmem_rd));
`endif
    endfunction

    function automatic bit [31:0] ref_src(input bit [4:0] r, input bit [31:0] v);
`ifdef EX_FWD_EN
        if (r != 0 && bus.exmem_reg_write && bus.exmem_rd == r) return bus.exmem_result;
        if (r != 0 && bus.memwb_reg_write && bus.memwb_rd == r) return bus.memwb_result;
`endif
        return v;
    endfunction

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", n, cyc, got, exp);
        end
    endtask

    // One clock: predict this cycle's outputs, then advance the model over the edge.
    task automatic step();
        exp_t      e;
        slot_t     nx;
        bit        hz;
        bit [4:0]  ic;
        if (!fwd_ovr) begin
            bus.exmem_reg_write = em_rw; bus.exmem_rd = em_rd; bus.exmem_result = em_res;
            bus.memwb_reg_write = mw_rw; bus.memwb_rd = mw_rd; bus.memwb_result = mw_res;
        end
        hz      = ref_hazard();
        e       = '{default: 0};
        e.stall = hz && !bus.flush;
        if (m_ex.valid) begin
            e.op1   = ref_src(m_ex.rs, m_ex.rsd);
            e.store = ref_src(m_ex.rt, m_ex.rtd);
            e.op2   = m_ex.src ? m_ex.imm : e.store;
            e.ctrl  = m_ex.ctrl;
        end
        e.valid = m_ex.valid; e.rw = m_ex.rw; e.mr = m_ex.mr; e.mw = m_ex.mw;
        e.ill   = m_ex.ill;   e.dest = m_ex.dest;
        sb.push_back(e);

        ic = ref_ctrl(bus.id_alu_op, bus.id_funct);
        nx = '{default: 0};
        if (!(rst || bus.flush || hz)) begin
            nx.valid = bus.id_valid;   nx.rw  = bus.id_reg_write;
            nx.mr    = bus.id_mem_read; nx.mw = bus.id_mem_write;
            nx.ill   = ic[4];          nx.ctrl = ic[3:0];
            nx.src   = bus.id_alu_src;
            nx.rs    = bus.id_rs;      nx.rt = bus.id_rt;
            nx.dest  = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
            nx.rsd   = bus.id_rs_data; nx.rtd = bus.id_rt_data; nx.imm = bus.id_imm;
        end
        last_stall = e.stall;
        @(posedge clk);
        mw_rw = em_rw; mw_rd = em_rd; mw_res = em_res;
        em_rw = m_ex.valid && m_ex.rw; em_rd = m_ex.dest; em_res = $urandom;
        if (rst) begin
            em_rw = 0; mw_rw = 0;
        end
        m_ex = nx;
        cyc++;
        #1;
    endtask

    task automatic set_id(input bit v, input bit [1:0] op, input bit [5:0] fn,
                          input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd,
                          input bit src, input bit dst, input bit rw, input bit mr,
                          input bit mw);
        bus.id_valid = v;   bus.id_alu_op = op;  bus.id_funct = fn;
        bus.id_rs = rs;     bus.id_rt = rt;      bus.id_rd = rd;
        bus.id_alu_src = src; bus.id_reg_dst = dst;
        bus.id_reg_write = rw; bus.id_mem_read = mr; bus.id_mem_write = mw;
        bus.id_rs_data = $urandom; bus.id_rt_data = $urandom; bus.id_imm = $urandom;
    endtask

    task automatic idle();
        set_id(0, 2'b00, 6'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    endtask

    // Issue the instruction on the id bus and keep it there while decode is stalled.
    task automatic issue_held();
        step();
        for (int i = 0; i < 4 && last_stall; i++) step();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("op_1",          bus.op_1,          e.op1);
                chk("op_2",          bus.op_2,          e.op2);
                chk("ex_store_data", bus.ex_store_data, e.store);
                chk("alu_ctrl",      32'(bus.alu_ctrl), 32'(e.ctrl));
                chk("ex_valid",      32'(bus.ex_valid), 32'(e.valid));
                chk("ex_reg_write",  32'(bus.ex_reg_write), 32'(e.rw));
                chk("ex_mem_read",   32'(bus.ex_mem_read), 32'(e.mr));
                chk("ex_mem_write",  32'(bus.ex_mem_write), 32'(e.mw));
                chk("ex_dest",       32'(bus.ex_dest), 32'(e.dest));
                chk("illegal_funct", 32'(bus.illegal_funct), 32'(e.ill));
                chk("stall_req",     32'(bus.stall_req), 32'(e.stall));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog cycle=%0d got=timeout exp=finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit [5:0] legal_f [6];
        legal_f = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
        rst = 1'b1;
        bus.flush = 0;
        bus.exmem_reg_write = 0; bus.exmem_rd = 0; bus.exmem_result = 0;
        bus.memwb_reg_write = 0; bus.memwb_rd = 0; bus.memwb_result = 0;
        set_id(1, 2'b10, 6'b100000, 5'd5, 5'd6, 5'd7, 0, 1, 1, 1, 1);
        em_rw = 0; em_rd = 0; em_res = 0; mw_rw = 0; mw_rd = 0; mw_res = 0;
        @(posedge clk);
        #1;
        m_ex = '{default: 0};

        // reset held with garbage on the decode bus
        repeat (2) begin
            set_id(1, 2'($urandom), 6'($urandom), 5'($urandom), 5'($urandom),
                   5'($urandom), 1, 1, 1, 1, 1);
            step();
        end
        rst = 1'b0;

        // add $7, $5, $6
        set_id(1, 2'b10, 6'b100000, 5'd5, 5'd6, 5'd7, 0, 1, 1, 0, 0);
        issue_held();
        idle(); step();

        // EX/MEM beats MEM/WB, then $0 target is never forwarded
        set_id(1, 2'b00, 6'd0, 5'd8, 5'd0, 5'd0, 1, 0, 0, 0, 0);
        issue_held();
        idle();
        fwd_ovr = 1;
        bus.exmem_reg_write = 1; bus.exmem_rd = 5'd8; bus.exmem_result = 32'h1234;
        bus.memwb_reg_write = 1; bus.memwb_rd = 5'd8; bus.memwb_result = 32'h5678;
        step();
        fwd_ovr = 0;
        set_id(1, 2'b00, 6'd0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0);
        issue_held();
        idle();
        fwd_ovr = 1;
        bus.exmem_reg_write = 1; bus.exmem_rd = 5'd0; bus.exmem_result = 32'h1234;
        bus.memwb_reg_write = 1; bus.memwb_rd = 5'd0; bus.memwb_result = 32'h5678;
        step();
        fwd_ovr = 0;

        // lw $9 then sub using $9
        set_id(1, 2'b00, 6'd0, 5'd1, 5'd9, 5'd0, 1, 0, 1, 1, 0);
        issue_held();
        set_id(1, 2'b10, 6'b100010, 5'd9, 5'd2, 5'd10, 0, 1, 1, 0, 0);
        issue_held();
        idle(); step();

        // flush coinciding with load-use
        set_id(1, 2'b00, 6'd0, 5'd1, 5'd9, 5'd0, 1, 0, 1, 1, 0);
        issue_held();
        set_id(1, 2'b10, 6'b100010, 5'd9, 5'd2, 5'd10, 0, 1, 1, 0, 0);
        bus.flush = 1;
        step();
        bus.flush = 0;
        idle(); step(); step();

        // illegal funct followed by a legal instruction
        set_id(1, 2'b10, 6'b111111, 5'd1, 5'd2, 5'd3, 0, 1, 1, 0, 0);
        issue_held();
        set_id(1, 2'b10, 6'b100000, 5'd1, 5'd2, 5'd4, 0, 1, 1, 0, 0);
        issue_held();
        idle(); step();

        // addi $3 then or using $3
        set_id(1, 2'b00, 6'd0, 5'd1, 5'd3, 5'd0, 1, 0, 1, 0, 0);
        issue_held();
        set_id(1, 2'b10, 6'b100101, 5'd3, 5'd4, 5'd5, 0, 1, 1, 0, 0);
        issue_held();
        idle(); step(); step();

        // randomized traffic on a small register window to provoke hazards
        for (int n = 0; n < 2000; n++) begin
            if (!last_stall) begin
                set_id($urandom_range(9) != 0, 2'($urandom),
                       ($urandom_range(7) == 0) ? 6'($urandom) : legal_f[$urandom_range(5)],
                       5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)),
                       1'($urandom), 1'($urandom), 1'($urandom),
                       $urandom_range(4) == 0, $urandom_range(5) == 0);
            end
            bus.flush = ($urandom_range(9) == 0);
            rst = ($urandom_range(99) == 0);
            fwd_ovr = ($urandom_range(3) == 0);
            if (fwd_ovr) begin
                bus.exmem_reg_write = 1'($urandom); bus.exmem_rd = 5'($urandom_range(3));
                bus.exmem_result = $urandom;
                bus.memwb_reg_write = 1'($urandom); bus.memwb_rd = 5'($urandom_range(3));
                bus.memwb_result = $urandom;
            end
            step();
        end
        rst = 0; bus.flush = 0; fwd_ovr = 0;

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain cycle=%0d got=%0d exp=0", cyc, sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
